counter_8: RTL and testbench
============================

COUNTER_8 -- requirements
Module: counter_8

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter SEG_ACTIVE_LOW, default 1, SHALL select segment polarity: 1 = lit segment drives 0, 0 = lit segment drives 1.
REQ-003 CLK  input  1  clock, all state updates on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 oQ  output  3  current count value, unsigned.
REQ-006 oDisplay  output  7  seven-segment pattern of oQ, bit order {g,f,e,d,c,b,a} (bit 6 = g, bit 0 = a).

Function
REQ-007 On each rising CLK edge with rst low, oQ SHALL increment by exactly 1.
REQ-008 Arithmetic SHALL be 3-bit modulo-8: 7 SHALL wrap to 0 on the next edge with no extra or skipped state.
REQ-009 oQ SHALL be driven directly from the state register, with no output logic after the register.
REQ-010 oDisplay SHALL be a purely combinational decode of oQ, valid in the same cycle, with zero latency.
REQ-011 With SEG_ACTIVE_LOW=1, the oDisplay codes SHALL be as follows. Digit 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30.
REQ-012 Continuing the SEG_ACTIVE_LOW=1 codes: digit 4 = 7'h19, 5 = 7'h12, 6 = 7'h02, 7 = 7'h78.
REQ-013 With SEG_ACTIVE_LOW=0, oDisplay SHALL be the bitwise inverse of the REQ-011/REQ-012 code.
REQ-014 The decoder SHALL be fully specified for all 8 inputs, and oDisplay SHALL never be X once oQ is known.
REQ-015 There SHALL be no enable, load or direction input; the counter counts on every non-reset edge.

Reset
REQ-016 rst is sampled only on the rising CLK edge; while high at an edge, oQ SHALL be 3'd0 after that edge.
REQ-017 A rst edge occurring mid-count, including at the wrap point, SHALL take priority over increment.
REQ-018 After the reset edge, oDisplay SHALL show digit 0 (7'h40 at default polarity).
REQ-019 Asserting rst between edges SHALL NOT change oQ until the next rising edge.
REQ-020 The first edge with rst low SHALL produce oQ=1.
REQ-021 Before the first reset edge, oQ is undefined; the bench SHALL apply reset before checking.

Configuration
REQ-022 Macro COUNTER_8_DISPLAY_EN SHALL control whether the seven-segment decoder is compiled in.
REQ-023 With COUNTER_8_DISPLAY_EN defined, the decoder SHALL be instantiated and oDisplay SHALL behave per REQ-010 to REQ-014.
REQ-024 With COUNTER_8_DISPLAY_EN undefined, no decoder logic SHALL exist.
REQ-025 With COUNTER_8_DISPLAY_EN undefined, oDisplay SHALL be constant all-segments-off: 7'h7F if SEG_ACTIVE_LOW=1, 7'h00 otherwise.
REQ-026 With COUNTER_8_DISPLAY_EN undefined, oQ behaviour SHALL be unchanged.

Structure
REQ-027 Shared package counter_8_pkg SHALL hold the count width constant (3) and the eight active-low segment code constants.
REQ-028 One sub-module, seg7_decoder (3-bit in, 7-bit out, with a polarity parameter), SHALL contain the decode.
REQ-029 counter_8 SHALL contain only the state register, the wrap logic and the decoder instance.

Verification
REQ-030 Scenario: rst=1 for one edge -> oQ=0, oDisplay=7'h40.
REQ-031 Scenario: release rst, apply 7 edges -> oQ=7, oDisplay=7'h78; 8th edge -> oQ=0, oDisplay=7'h40.
REQ-032 Scenario: release rst, apply 19 consecutive edges -> oQ=3, oDisplay=7'h30 (19 mod 8).
REQ-033 Scenario: at oQ=5, raise rst between edges -> oQ stays 5 until the edge, then becomes 0; with rst held, it remains 0.
REQ-034 Scenario: rst high at the edge where oQ=7 -> oQ=0 (reset wins over wrap); next non-reset edge -> oQ=1.
REQ-035 Scenario: SEG_ACTIVE_LOW=0 -> oQ=0 gives 7'h3F.
REQ-036 Scenario: COUNTER_8_DISPLAY_EN undefined -> oDisplay constant 7'h7F while oQ still cycles 0 to 7.

Source files
------------

// File: rtl/counter_8_pkg.sv
// Shared constants for the 3-bit counter: count width and active-low seven-segment codes.
// Codes are ordered {g,f,e,d,c,b,a}; a 0 bit lights a segment.
package counter_8_pkg;

  localparam int unsigned CountWidth = 3;
  localparam int unsigned SegWidth   = 7;

  localparam logic [SegWidth-1:0] SegLow0 = 7'h40;
  localparam logic [SegWidth-1:0] SegLow1 = 7'h79;
  localparam logic [SegWidth-1:0] SegLow2 = 7'h24;
  localparam logic [SegWidth-1:0] SegLow3 = 7'h30;
  localparam logic [SegWidth-1:0] SegLow4 = 7'h19;
  localparam logic [SegWidth-1:0] SegLow5 = 7'h12;
  localparam logic [SegWidth-1:0] SegLow6 = 7'h02;
  localparam logic [SegWidth-1:0] SegLow7 = 7'h78;

  // All segments dark in active-low encoding.
  localparam logic [SegWidth-1:0] SegLowOff = 7'h7F;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 3-bit to seven-segment decoder, bit order {g,f,e,d,c,b,a}.
// ActiveLow selects whether a lit segment drives 0 (1) or 1 (0).
module seg7_decoder
  import counter_8_pkg::*;
#(
  parameter bit ActiveLow = 1'b1
) (
  input  logic [CountWidth-1:0] value,
  output logic [SegWidth-1:0]   segments
);

  logic [SegWidth-1:0] seg_low;

  always_comb begin
    seg_low = SegLow0;
    unique case (value)
      3'd0: seg_low = SegLow0;
      3'd1: seg_low = SegLow1;
      3'd2: seg_low = SegLow2;
      3'd3: seg_low = SegLow3;
      3'd4: seg_low = SegLow4;
      3'd5: seg_low = SegLow5;
      3'd6: seg_low = SegLow6;
      3'd7: seg_low = SegLow7;
      default: seg_low = SegLow0;
    endcase
  end

  assign segments = ActiveLow ? seg_low : ~seg_low;

endmodule

// File: rtl/counter_8.sv
// Free-running modulo-8 counter with optional seven-segment display output.
// Define COUNTER_8_DISPLAY_EN to build the decoder; otherwise oDisplay is held all-off.
module counter_8
  import counter_8_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  CLK,
  input  logic                  rst,
  output logic [CountWidth-1:0] oQ,
  output logic [SegWidth-1:0]   oDisplay
);

  logic [CountWidth-1:0] count_q;
  logic [CountWidth-1:0] count_d;

  // Natural 3-bit overflow gives the 7 -> 0 wrap.
  assign count_d = count_q + 1'b1;

  always_ff @(posedge CLK) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign oQ = count_q;

`ifdef COUNTER_8_DISPLAY_EN
  seg7_decoder #(
    .ActiveLow (SEG_ACTIVE_LOW)
  ) u_seg7_decoder (
    .value    (count_q),
    .segments (oDisplay)
  );
`else
  assign oDisplay = SEG_ACTIVE_LOW ? SegLowOff : ~SegLowOff;
`endif

endmodule

// File: tb/tb_counter_8.sv
// Scoreboard bench for counter_8: expected counts are queued as each edge is driven
// and popped after the edge; both display polarities are checked against a local table.
module tb_counter_8;

  logic       CLK = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] q_hi;
  logic [6:0] disp_hi;
  logic [2:0] q_lo;
  logic [6:0] disp_lo;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [2:0] model_q;
  logic [2:0] exp_queue[$];

  always #5 CLK = ~CLK;

  counter_8 #(.SEG_ACTIVE_LOW(1'b1)) dut (
    .CLK      (CLK),
    .rst      (rst),
    .oQ       (q_hi),
    .oDisplay (disp_hi)
  );

  counter_8 #(.SEG_ACTIVE_LOW(1'b0)) dut_lo (
    .CLK      (CLK),
    .rst      (rst),
    .oQ       (q_lo),
    .oDisplay (disp_lo)
  );

  function automatic logic [6:0] seg_expect(input logic [2:0] q, input bit active_low);
    logic [6:0] code;
`ifdef COUNTER_8_DISPLAY_EN
    case (q)
      3'd0: code = 7'h40;
      3'd1: code = 7'h79;
      3'd2: code = 7'h24;
      3'd3: code = 7'h30;
      3'd4: code = 7'h19;
      3'd5: code = 7'h12;
      3'd6: code = 7'h02;
      default: code = 7'h78;
    endcase
`else
    code = 7'h7F;
`endif
    return active_low ? code : ~code;
  endfunction

  task automatic check_val(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive rst for the coming edge, queue the expected count, then compare after the edge.
  task automatic tick(input logic r, input string tag);
    logic [2:0] e;
    @(negedge CLK);
    rst = r;
    model_q = r ? 3'd0 : model_q + 3'd1;
    exp_queue.push_back(model_q);
    @(posedge CLK);
    #1;
    if (exp_queue.size() == 0) begin
      check_val({tag, "_queue_empty"}, 7'd1, 7'd0);
    end else begin
      e = exp_queue.pop_front();
      check_val({tag, "_q"},       {4'd0, q_hi},  {4'd0, e});
      check_val({tag, "_disp"},    disp_hi,       seg_expect(e, 1'b1));
      check_val({tag, "_q_lo"},    {4'd0, q_lo},  {4'd0, e});
      check_val({tag, "_disp_lo"}, disp_lo,       seg_expect(e, 1'b0));
    end
  endtask

  initial begin
    model_q = 3'd0;

    // Reset for one edge: count 0, digit 0 shown (0x3F on the active-high instance).
    tick(1'b1, "reset");

    // Seven edges up to 7, eighth wraps to 0.
    for (int i = 1; i <= 8; i++) tick(1'b0, $sformatf("wrap%0d", i));

    // Nineteen consecutive edges from reset end on 3.
    tick(1'b1, "reset2");
    for (int i = 1; i <= 19; i++) tick(1'b0, $sformatf("run19_%0d", i));
    check_val("run19_final", {4'd0, q_hi}, 7'd3);

    // Count to 5, raise rst between edges: no change until the edge.
    tick(1'b1, "reset3");
    for (int i = 1; i <= 5; i++) tick(1'b0, $sformatf("to5_%0d", i));
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_rst_hold", {4'd0, q_hi}, {4'd0, model_q});
    tick(1'b1, "mid_rst_edge");
    tick(1'b1, "rst_held");

    // Reset arriving at the wrap point wins, then counting resumes at 1.
    for (int i = 1; i <= 7; i++) tick(1'b0, $sformatf("to7_%0d", i));
    check_val("at7", {4'd0, q_hi}, 7'd7);
    tick(1'b1, "rst_at_wrap");
    tick(1'b0, "after_rst");
    check_val("after_rst_is1", {4'd0, q_hi}, 7'd1);

    check_val("queue_drained", {1'b0, 6'(exp_queue.size())}, 7'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
